// File: rtl/writeback_pipe_unit.sv
// MEM/WB pipeline register. Selects the write-back result and extracts load data.
// It also counts instructions that are accepted into WB.
module writeback_pipe_unit #(
    parameter int XLEN      = 64,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_m,
    input  logic                 reg_write_m,
    input  logic [4:0]           rd_m,
    input  logic [1:0]           result_src_m,
    input  logic [2:0]           load_funct3_m,
    input  logic [2:0]           addr_low_m,
    input  logic [XLEN-1:0]      alu_result_m,
    input  logic [XLEN-1:0]      read_data_m,
    input  logic [XLEN-1:0]      pc_plus4_m,
    input  logic                 stall_w,
    input  logic                 flush_w,
    output logic                 valid_w,
    output logic [4:0]           rd_w,
    output logic                 reg_write_en_w,
    output logic [XLEN-1:0]      result_w,
    output logic [CNT_WIDTH-1:0] instret_w
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    logic [63:0]           w_raw;
    logic [2:0]            w_lane;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_word;
    logic [63:0]           w_ext;
    logic [XLEN-1:0]       w_load_data;
    logic [XLEN-1:0]       w_result_next;

    logic                  r_valid;
    logic                  r_reg_write;
    logic [4:0]            r_rd;
    logic [XLEN-1:0]       r_result;
    logic [CNT_WIDTH-1:0]  r_instret;

    // The datapath is widened to 64 bits so one extractor serves both XLEN builds.
    // In a 32-bit build the upper word does not exist, so lane bit 2 is forced low.
    assign w_raw  = 64'(read_data_m);
    assign w_lane = (XLEN == 32) ? {1'b0, addr_low_m[1:0]} : addr_low_m;
    assign w_byte = w_raw[8 * w_lane +: 8];
    assign w_half = w_raw[16 * w_lane[2:1] +: 16];
    assign w_word = w_raw[32 * w_lane[2] +: 32];

    always_comb begin
        w_ext = w_raw;
        case (load_funct3_m)
            3'b000:  w_ext = {{56{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{48{w_half[15]}}, w_half};
            3'b010:  w_ext = {{32{w_word[31]}}, w_word};
            3'b100:  w_ext = {56'd0, w_byte};
            3'b101:  w_ext = {48'd0, w_half};
            3'b110:  w_ext = {32'd0, w_word};
            default: w_ext = w_raw;
        endcase
    end

    assign w_load_data = w_ext[XLEN-1:0];

    always_comb begin
        w_result_next = '0;
        case (result_src_m)
            SRC_ALU:  w_result_next = alu_result_m;
            SRC_LOAD: w_result_next = w_load_data;
            SRC_PC4:  w_result_next = pc_plus4_m;
            default:  w_result_next = '0;
        endcase
    end

    // On a flush, rd and result are left alone because a killed slot never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= 5'd0;
            r_result    <= '0;
            r_instret   <= '0;
        end else if (flush_w) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (!stall_w) begin
            r_valid     <= valid_m;
            r_reg_write <= reg_write_m;
            r_rd        <= rd_m;
            r_result    <= w_result_next;
            if (valid_m) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end
        end
    end

    assign valid_w        = r_valid;
    assign rd_w           = r_rd;
    assign result_w       = r_result;
    assign instret_w      = r_instret;
    assign reg_write_en_w = r_valid & r_reg_write & (r_rd != 5'd0);

endmodule
